l2_refill_ctrl: RTL and testbench

- Sits directly downstream of the L2 cache, between its miss output and main memory.
- Accepts one L2 miss address at a time and issues a single burst read to main memory.
- Collects BLOCK_WORDS data beats, forwards the requested (critical) word as soon as it arrives, then returns the complete block to L2 as a one-cycle fill.
- Guards the memory burst with a timeout and flags an error if memory stalls.

---
 rtl/l2_refill_ctrl_if.sv | 34 +++
 rtl/l2_refill_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_l2_refill_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_refill_ctrl_if.sv
// Handshake and data bundle between L2 (miss/fill side), main memory and the refill controller.
// master = refill controller, slave = environment (L2 cache plus memory).
interface l2_refill_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4
);
    logic                              miss_valid;
    logic                              miss_ready;
    logic [ADDR_WIDTH-1:0]             miss_address;
    logic                              mem_req_valid;
    logic                              mem_req_ready;
    logic [ADDR_WIDTH-1:0]             mem_address;
    logic                              mem_rdata_valid;
    logic [DATA_WIDTH-1:0]             mem_rdata;
    logic                              crit_valid;
    logic [DATA_WIDTH-1:0]             crit_data;
    logic                              fill_valid;
    logic [ADDR_WIDTH-1:0]             fill_address;
    logic [BLOCK_WORDS*DATA_WIDTH-1:0] fill_data;
    logic                              timeout_err;

    modport master (
        input  miss_valid, miss_address, mem_req_ready, mem_rdata_valid, mem_rdata,
        output miss_ready, mem_req_valid, mem_address, crit_valid, crit_data,
               fill_valid, fill_address, fill_data, timeout_err
    );

    modport slave (
        output miss_valid, miss_address, mem_req_ready, mem_rdata_valid, mem_rdata,
        input  miss_ready, mem_req_valid, mem_address, crit_valid, crit_data,
               fill_valid, fill_address, fill_data, timeout_err
    );
endinterface

// File: rtl/l2_refill_ctrl.sv
// L2 refill controller: one burst read per miss, early critical-word forward, one-cycle block fill.
// Build macro CRITICAL_WORD_FIRST_EN: burst starts at the requested word and memory wraps.
module l2_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BLOCK_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    l2_refill_ctrl_if.master bus
);
    localparam int OFF_BITS = $clog2(BLOCK_WORDS * 4);
    localparam int IDX_W    = $clog2(BLOCK_WORDS);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FILL = 2'd3
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] block_align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    state_e                                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic [IDX_W-1:0]                       beat_q, beat_d;
    logic [TMO_W-1:0]                       tmo_q, tmo_d;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] blk_q, blk_d;
    logic                                   miss_ready_q, miss_ready_d;
    logic                                   mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0]                  mem_address_q, mem_address_d;
    logic                                   crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0]                  crit_data_q, crit_data_d;
    logic                                   fill_valid_q, fill_valid_d;
    logic [ADDR_WIDTH-1:0]                  fill_address_q, fill_address_d;
    logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                                   timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0]                       crit_idx_s, start_s, slot_s;

    assign crit_idx_s = addr_q[OFF_BITS-1:2];
`ifdef CRITICAL_WORD_FIRST_EN
    assign start_s = crit_idx_s;
`else
    assign start_s = {IDX_W{1'b0}};
`endif
    // Beats land in wrap order starting at start_s; the narrow add gives the modulo for free.
    assign slot_s = start_s + beat_q;

    // Next-state, buffer and output-register computation.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        beat_d         = beat_q;
        tmo_d          = tmo_q;
        blk_d          = blk_q;
        mem_address_d  = mem_address_q;
        crit_valid_d   = 1'b0;
        crit_data_d    = crit_data_q;
        fill_valid_d   = 1'b0;
        fill_address_d = fill_address_q;
        fill_data_d    = fill_data_q;
        timeout_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    addr_d  = bus.miss_address;
                    state_d = S_REQ;
`ifdef CRITICAL_WORD_FIRST_EN
                    mem_address_d = word_align(bus.miss_address);
`else
                    mem_address_d = block_align(bus.miss_address);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                    beat_d  = {IDX_W{1'b0}};
                    tmo_d   = {TMO_W{1'b0}};
                    blk_d   = '0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.mem_rdata_valid) begin
                    blk_d[slot_s] = bus.mem_rdata;
                    beat_d        = beat_q + IDX_W'(1);
                    tmo_d         = {TMO_W{1'b0}};
                    if (slot_s == crit_idx_s) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = bus.mem_rdata;
                    end else begin
                        crit_valid_d = 1'b0;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d        = S_FILL;
                        fill_valid_d   = 1'b1;
                        fill_address_d = block_align(addr_q);
                        fill_data_d    = blk_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    // Memory went silent: abandon the burst and drop whatever arrived.
                    timeout_err_d = 1'b1;
                    blk_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        miss_ready_d    = (state_d == S_IDLE);
        mem_req_valid_d = (state_d == S_REQ);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            tmo_q           <= '0;
            blk_q           <= '0;
            miss_ready_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_address_q   <= '0;
            crit_valid_q    <= 1'b0;
            crit_data_q     <= '0;
            fill_valid_q    <= 1'b0;
            fill_address_q  <= '0;
            fill_data_q     <= '0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            beat_q          <= beat_d;
            tmo_q           <= tmo_d;
            blk_q           <= blk_d;
            miss_ready_q    <= miss_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_address_q   <= mem_address_d;
            crit_valid_q    <= crit_valid_d;
            crit_data_q     <= crit_data_d;
            fill_valid_q    <= fill_valid_d;
            fill_address_q  <= fill_address_d;
            fill_data_q     <= fill_data_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign bus.miss_ready    = miss_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.crit_valid    = crit_valid_q;
    assign bus.crit_data     = crit_data_q;
    assign bus.fill_valid    = fill_valid_q;
    assign bus.fill_address  = fill_address_q;
    assign bus.fill_data     = fill_data_q;
    assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Directed bench for l2_refill_ctrl: per-cycle behavioural model plus literal expectations.
// Works for both builds (CRITICAL_WORD_FIRST_EN defined or not).
module tb_l2_refill_ctrl;
    localparam int AW = 32, DW = 32, BW = 4, TMO = 64;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit          CWF         = 1'b1;
    localparam logic [31:0] T1_MEM_ADDR = 32'h0000_1238;
    localparam int          T1_CRIT_OFF = 3;
    localparam logic [31:0] BP_MEM_ADDR = 32'h0000_6008;
    localparam logic [31:0] BA_MEM_ADDR = 32'h0000_4004;
    localparam logic [31:0] BB_MEM_ADDR = 32'h0000_500C;
`else
    localparam bit          CWF         = 1'b0;
    localparam logic [31:0] T1_MEM_ADDR = 32'h0000_1230;
    localparam int          T1_CRIT_OFF = 5;
    localparam logic [31:0] BP_MEM_ADDR = 32'h0000_6000;
    localparam logic [31:0] BA_MEM_ADDR = 32'h0000_4000;
    localparam logic [31:0] BB_MEM_ADDR = 32'h0000_5000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) bus ();

    l2_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BW*DW-1:0] act, input logic [BW*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_pending, m_burst, m_filling;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_beats[$];
    int               m_idle;
    bit               e_miss_ready, e_req_valid, e_crit_valid, e_fill_valid, e_tmo;
    logic [AW-1:0]    e_mem_addr, e_fill_addr;
    logic [DW-1:0]    e_crit_data;
    logic [BW*DW-1:0] e_fill_data;

    task automatic model_reset();
        m_pending = 1'b0; m_burst = 1'b0; m_filling = 1'b0; m_idle = 0;
        m_beats.delete();
        e_miss_ready = 1'b1; e_req_valid = 1'b0; e_crit_valid = 1'b0;
        e_fill_valid = 1'b0; e_tmo = 1'b0;
    endtask

    // Expected outputs of the next cycle from this cycle's inputs.
    task automatic model_step();
        int first;
        int word;
        int widx;
        e_crit_valid = 1'b0; e_fill_valid = 1'b0; e_tmo = 1'b0;
        widx  = int'(m_addr[3:2]);
        first = CWF ? widx : 0;
        if (m_filling) begin
            m_filling = 1'b0;
        end else if (m_pending) begin
            if (bus.mem_req_ready) begin
                m_pending = 1'b0; m_burst = 1'b1; m_idle = 0;
                m_beats.delete();
            end
        end else if (m_burst) begin
            if (bus.mem_rdata_valid) begin
                word = (first + m_beats.size()) % BW;
                m_beats.push_back(bus.mem_rdata);
                m_idle = 0;
                if (word == widx) begin
                    e_crit_valid = 1'b1; e_crit_data = bus.mem_rdata;
                end
                if (m_beats.size() == BW) begin
                    m_burst = 1'b0; m_filling = 1'b1; e_fill_valid = 1'b1;
                    e_fill_addr = {m_addr[AW-1:4], 4'h0};
                    for (int i = 0; i < BW; i++) e_fill_data[((first + i) % BW)*DW +: DW] = m_beats[i];
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    e_tmo = 1'b1; m_burst = 1'b0;
                end
            end
        end else if (bus.miss_valid) begin
            m_pending = 1'b1;
            m_addr    = bus.miss_address;
            e_mem_addr = CWF ? {m_addr[AW-1:2], 2'b00} : {m_addr[AW-1:4], 4'h0};
        end
        e_miss_ready = !(m_pending || m_burst || m_filling);
        e_req_valid  = m_pending;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk_bit("rst_miss_ready", bus.miss_ready, 1'b1);
            chk_bit("rst_req_valid", bus.mem_req_valid, 1'b0);
            chk_bit("rst_crit_valid", bus.crit_valid, 1'b0);
            chk_bit("rst_fill_valid", bus.fill_valid, 1'b0);
            chk_bit("rst_timeout_err", bus.timeout_err, 1'b0);
        end else begin
            chk_bit("m_miss_ready", bus.miss_ready, e_miss_ready);
            chk_bit("m_req_valid", bus.mem_req_valid, e_req_valid);
            if (e_req_valid) chk_word("m_mem_address", bus.mem_address, e_mem_addr);
            chk_bit("m_crit_valid", bus.crit_valid, e_crit_valid);
            if (e_crit_valid) chk_word("m_crit_data", bus.crit_data, e_crit_data);
            chk_bit("m_fill_valid", bus.fill_valid, e_fill_valid);
            if (e_fill_valid) begin
                chk_word("m_fill_address", bus.fill_address, e_fill_addr);
                chk_blk("m_fill_data", bus.fill_data, e_fill_data);
            end
            chk_bit("m_timeout_err", bus.timeout_err, e_tmo);
            model_step();
        end
    end

    // ---------------- pulse monitor ----------------
    int               cyc = 0;
    int               crit_cnt = 0, crit_cyc = 0, fill_cnt = 0, fill_cyc = 0, tmo_cnt = 0, tmo_cyc = 0;
    logic [DW-1:0]    crit_seen;
    logic [AW-1:0]    fill_addr_seen;
    logic [BW*DW-1:0] fill_seen;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.crit_valid === 1'b1) begin
            crit_cnt++; crit_cyc = cyc; crit_seen = bus.crit_data;
        end
        if (bus.fill_valid === 1'b1) begin
            fill_cnt++; fill_cyc = cyc; fill_addr_seen = bus.fill_address; fill_seen = bus.fill_data;
        end
        if (bus.timeout_err === 1'b1) begin
            tmo_cnt++; tmo_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.miss_valid = 1'b0; bus.miss_address = '0; bus.mem_req_ready = 1'b0;
        bus.mem_rdata_valid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic send_beats(input logic [AW-1:0] addr, input logic [DW-1:0] base, input int n);
        int slot;
        for (int k = 0; k < n; k++) begin
            slot = CWF ? (int'(addr[3:2]) + k) % BW : k;
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = base + DW'(slot);
            next_cycle();
        end
        bus.mem_rdata_valid = 1'b0;
    endtask

    // One complete refill starting in IDLE; word i of the block carries base+i.
    task automatic run_miss(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] exp_mem,
                            input logic [DW-1:0] base, input int req_wait, input bit hold_next,
                            input logic [AW-1:0] next_addr, output int c0);
        int f0, k0, t0;
        f0 = fill_cnt; k0 = crit_cnt; t0 = tmo_cnt;
        bus.miss_valid = 1'b1; bus.miss_address = addr;
        bus.mem_req_ready = 1'b0; bus.mem_rdata_valid = 1'b0;
        c0 = cyc;
        next_cycle();
        if (hold_next) bus.miss_address = next_addr;
        else bus.miss_valid = 1'b0;
        for (int w = 0; w < req_wait; w++) begin
            @(negedge clk);
            chk_bit({tag, "_bp_req_valid"}, bus.mem_req_valid, 1'b1);
            chk_word({tag, "_bp_mem_address"}, bus.mem_address, exp_mem);
            chk_bit({tag, "_bp_miss_ready"}, bus.miss_ready, 1'b0);
            chk_bit({tag, "_bp_timeout"}, bus.timeout_err, 1'b0);
            next_cycle();
        end
        bus.mem_req_ready = 1'b1;
        bus.mem_rdata_valid = hold_next;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_word({tag, "_mem_address"}, bus.mem_address, exp_mem);
        next_cycle();
        bus.mem_req_ready = 1'b0;
        send_beats(addr, base, BW);
        bus.mem_rdata_valid = hold_next;
        bus.mem_rdata = 32'hBAD0_0000;
        @(negedge clk);
        next_cycle();
        bus.mem_rdata_valid = 1'b0;
        chk_int({tag, "_fill_count"}, fill_cnt - f0, 1);
        chk_int({tag, "_crit_count"}, crit_cnt - k0, 1);
        chk_int({tag, "_timeout_count"}, tmo_cnt - t0, 0);
        chk_int({tag, "_fill_latency"}, fill_cyc - c0, 6 + req_wait);
    endtask

    initial begin
        int c0, b, f0, t0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk_word("reset_mem_address", bus.mem_address, 32'h0);
        chk_word("reset_fill_address", bus.fill_address, 32'h0);
        chk_blk("reset_fill_data", bus.fill_data, 128'h0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Basic refill with hand-computed values.
        run_miss("t1", 32'h0000_1238, T1_MEM_ADDR, 32'hA000_0000, 0, 1'b0, 32'h0, c0);
        chk_word("t1_crit_data", crit_seen, 32'hA000_0002);
        chk_int("t1_crit_offset", crit_cyc - c0, T1_CRIT_OFF);
        chk_word("t1_fill_address", fill_addr_seen, 32'h0000_1230);
        chk_blk("t1_fill_data", fill_seen, 128'hA0000003_A0000002_A0000001_A0000000);
        @(negedge clk);
        chk_bit("t1_miss_ready_back", bus.miss_ready, 1'b1);
        next_cycle();

        // Request backpressure for 5 cycles.
        run_miss("bp", 32'h0000_6008, BP_MEM_ADDR, 32'hD000_0000, 5, 1'b0, 32'h0, c0);
        chk_blk("bp_fill_data", fill_seen, 128'hD0000003_D0000002_D0000001_D0000000);
        next_cycle();

        // One beat then silence.
        f0 = fill_cnt; t0 = tmo_cnt;
        bus.miss_valid = 1'b1; bus.miss_address = 32'h0000_2004;
        next_cycle();
        bus.miss_valid = 1'b0; bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0; bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hE000_0000;
        b = cyc;
        next_cycle();
        bus.mem_rdata_valid = 1'b0;
        repeat (70) next_cycle();
        chk_int("to_pulses", tmo_cnt - t0, 1);
        chk_int("to_offset", tmo_cyc - b, 65);
        chk_int("to_no_fill", fill_cnt - f0, 0);
        @(negedge clk);
        chk_bit("to_idle_miss_ready", bus.miss_ready, 1'b1);
        next_cycle();

        // Reset after 2 of 4 beats, stray beat after release, then a fresh miss.
        f0 = fill_cnt;
        bus.miss_valid = 1'b1; bus.miss_address = 32'h0000_3010;
        next_cycle();
        bus.miss_valid = 1'b0; bus.mem_req_ready = 1'b1;
        next_cycle();
        bus.mem_req_ready = 1'b0;
        send_beats(32'h0000_3010, 32'hF000_0000, 2);
        rst_n = 1'b0;
        bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 32'hF000_0002;
        @(negedge clk);
        chk_bit("rmb_miss_ready", bus.miss_ready, 1'b1);
        chk_word("rmb_mem_address", bus.mem_address, 32'h0);
        chk_word("rmb_crit_data", bus.crit_data, 32'h0);
        chk_word("rmb_fill_address", bus.fill_address, 32'h0);
        chk_blk("rmb_fill_data", bus.fill_data, 128'h0);
        next_cycle();
        rst_n = 1'b1; bus.mem_rdata = 32'hF000_0003;
        next_cycle();
        bus.mem_rdata_valid = 1'b0;
        repeat (3) next_cycle();
        chk_int("rmb_no_fill", fill_cnt - f0, 0);
        run_miss("rmb_fresh", 32'h0000_3010, 32'h0000_3010, 32'h1100_0000, 0, 1'b0, 32'h0, c0);
        chk_blk("rmb_fresh_fill", fill_seen, 128'h11000003_11000002_11000001_11000000);
        next_cycle();

        // Second miss held during the first refill, stray beats in REQ and FILL.
        run_miss("b2b_a", 32'h0000_4004, BA_MEM_ADDR, 32'hB000_0000, 0, 1'b1, 32'h0000_500C, c0);
        chk_blk("b2b_a_fill", fill_seen, 128'hB0000003_B0000002_B0000001_B0000000);
        run_miss("b2b_b", 32'h0000_500C, BB_MEM_ADDR, 32'hC000_0000, 0, 1'b0, 32'h0, c0);
        chk_word("b2b_b_fill_address", fill_addr_seen, 32'h0000_5000);
        chk_blk("b2b_b_fill", fill_seen, 128'hC0000003_C0000002_C0000001_C0000000);
        chk_word("b2b_b_crit", crit_seen, 32'hC000_0003);
        repeat (3) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
